// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, arbiter state type and timeout sizing helper
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_FRAME_BITS = 10;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} uart_arb_state_t;
  function automatic int frame_timeout(input int clks_per_bit);
    return 2 * clks_per_bit * UART_FRAME_BITS;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake, transmitter control and arbiter status bundle
// slave = arbiter side, master = requesters/transmitter side
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = UART_DATA_W
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] req_done;
  logic uart_start_tx;
  logic [DATA_W-1:0] uart_tx_data;
  logic uart_tx_busy;
  logic uart_tx_done;
  logic [IW-1:0] grant_id;
  logic active;
  logic timeout_err;
  modport slave (
    input req_valid, req_data, uart_tx_busy, uart_tx_done,
    output req_ready, req_done, uart_start_tx, uart_tx_data, grant_id, active, timeout_err
  );
  modport master (
    output req_valid, req_data, uart_tx_busy, uart_tx_done,
    input req_ready, req_done, uart_start_tx, uart_tx_data, grant_id, active, timeout_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr
// req/ptr in; one-hot gnt, its index gnt_id, any = some request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_id,
  output logic               any
);
  int best, sel;
  always_comb begin
    best = NUM_REQ;
    sel = 0;
    gnt = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (req[k] && (k + NUM_REQ - int'(ptr)) % NUM_REQ < best) begin
        best = (k + NUM_REQ - int'(ptr)) % NUM_REQ;
        sel = k;
      end
    any = best < NUM_REQ;
    gnt_id = IW'(sel);
    for (int k = 0; k < NUM_REQ; k++) gnt[k] = any && sel == k;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_transmitter among NUM_REQ byte requesters
// clk/rst plain; bus (slave) carries requester handshake, transmitter control and status
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = UART_DATA_W,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  uart_arb_state_t state, state_d;
  logic [IW-1:0] ptr, ptr_nx, gnt_id;
  logic [NUM_REQ-1:0] gnt, done_d;
  logic [DATA_W-1:0] sel_data;
  logic [CW-1:0] cnt;
  logic any, tx_ok, expired, fin, unused_busy;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (.req(bus.req_valid), .ptr(ptr), .gnt(gnt), .gnt_id(gnt_id), .any(any));
  always_comb begin
    tx_ok = state == WAIT && bus.uart_tx_done;
    // a done arriving on the limit cycle wins over the timeout
    expired = state == WAIT && !bus.uart_tx_done && cnt == CW'(TIMEOUT_CYCLES);
    fin = tx_ok || expired;
    state_d = state == IDLE ? (any ? LAUNCH : IDLE) : state == LAUNCH ? WAIT : fin ? IDLE : WAIT;
    ptr_nx = bus.grant_id == IW'(NUM_REQ - 1) ? '0 : bus.grant_id + 1'b1;
    sel_data = '0;
    done_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_data = sel_data | (gnt[k] ? bus.req_data[k*DATA_W +: DATA_W] : '0);
      done_d[k] = tx_ok && bus.grant_id == IW'(k);
    end
  end
  assign bus.req_ready = state == IDLE ? gnt : '0;
  assign bus.uart_start_tx = state == LAUNCH;
  assign bus.active = state != IDLE;
  assign unused_busy = bus.uart_tx_busy;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
      bus.uart_tx_data <= '0;
      bus.grant_id <= '0;
      bus.req_done <= '0;
      bus.timeout_err <= '0;
    end else begin
      bus.req_done <= done_d;
      bus.timeout_err <= expired;
      if (state == IDLE && any) begin
        bus.uart_tx_data <= sel_data;
        bus.grant_id <= gnt_id;
        cnt <= '0;
      end else if (state != IDLE) cnt <= cnt + 1'b1;
      if (fin) ptr <= ptr_nx;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a transaction-level model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int TO = 8;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus();
  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_pass = 0;
  int m_owner = -1, m_ptr = 0, m_gid = 0, m_cyc = 0, m_launch = 0;
  logic [7:0] m_data = 0;
  logic [3:0] m_done = 0;
  logic m_to = 0;
  logic start_seen = 0;
  logic [3:0] hs_mask = 0;
  logic [7:0] rx_q[$];
  int gnt_q[$];
  int k = 0, bfm_delay = 0;
  bit rnd = 0, refill = 0;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic int rr_pick(logic [3:0] v, int p);
    for (int j = 0; j < N; j++) begin
      int q;
      q = (p + j) % N;
      if (v[q[1:0]]) return q;
    end
    return -1;
  endfunction

  task automatic set_data(int i, logic [7:0] d);
    bus.req_data = (bus.req_data & ~(32'hFF << (8 * i))) | (32'(d) << (8 * i));
  endtask

  // model: one owner at a time, launch cycle index, done/timeout judged by elapsed cycles
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_gid = 0; m_data = 0; m_done = 0; m_to = 0; m_cyc = 0; m_launch = 0;
    end else begin
      int w;
      m_done = 0;
      m_to = 0;
      if (m_owner < 0) begin
        w = rr_pick(bus.req_valid, m_ptr);
        if (w >= 0) begin
          m_owner = w;
          m_gid = w;
          m_data = 8'(bus.req_data >> (8 * w));
          m_launch = m_cyc + 1;
        end
      end else if (m_cyc > m_launch) begin
        if (bus.uart_tx_done) begin
          m_done = 4'(1 << m_owner);
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end else if (m_cyc - m_launch == TO) begin
          m_to = 1;
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
      m_cyc++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      logic [3:0] er;
      int w;
      er = 0;
      if (m_owner < 0) begin
        w = rr_pick(bus.req_valid, m_ptr);
        if (w >= 0) er = 4'(1 << w);
      end
      chk("req_ready", bus.req_ready, er);
      chk("start_tx", bus.uart_start_tx, m_owner >= 0 && m_cyc == m_launch);
      chk("active", bus.active, m_owner >= 0);
      chk("tx_data", bus.uart_tx_data, m_data);
      chk("grant_id", bus.grant_id, m_gid);
      chk("req_done", bus.req_done, m_done);
      chk("timeout_err", bus.timeout_err, m_to);
    end
  end

  initial forever begin
    @(negedge clk);
    start_seen = bus.uart_start_tx;
    hs_mask = bus.req_valid & bus.req_ready;
    if (bus.uart_start_tx) rx_q.push_back(bus.uart_tx_data);
    for (int i = 0; i < N; i++) if (hs_mask[i]) gnt_q.push_back(i);
  end

  // one cycle: transmitter BFM answers start_tx after k cycles (0 = never), requesters drop on handshake
  task automatic step();
    @(posedge clk);
    #2;
    if (rst) k = 0;
    else if (start_seen) k = rnd ? ($urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 10))) : bfm_delay;
    bus.uart_tx_done = 0;
    if (k > 0) begin
      k--;
      bus.uart_tx_done = k == 0;
    end
    if (rnd && $urandom_range(0, 24) == 0) bus.uart_tx_done = 1;
    bus.uart_tx_busy = k > 0;
    bus.req_valid = bus.req_valid & ~hs_mask;
    if (refill) bus.req_valid = 4'hF;
    if (rnd)
      for (int i = 0; i < N; i++)
        if (bus.req_valid[i] && $urandom_range(0, 15) == 0) bus.req_valid[i] = 0;
        else if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
          bus.req_valid[i] = 1;
          set_data(i, 8'($urandom));
        end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.active && t < 100) begin
      step();
      t++;
    end
    if (bus.active) chk("wait_idle", 0, 1);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ready"}, bus.req_ready, 0);
    chk({tag, "_start"}, bus.uart_start_tx, 0);
    chk({tag, "_active"}, bus.active, 0);
    chk({tag, "_data"}, bus.uart_tx_data, 0);
    chk({tag, "_gid"}, bus.grant_id, 0);
    chk({tag, "_done"}, bus.req_done, 0);
    chk({tag, "_to"}, bus.timeout_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 0;
    bus.req_data = 0;
    bus.uart_tx_done = 0;
    bus.uart_tx_busy = 0;
    repeat (3) step();
    #1;
    chk_zero("rst");
    rst = 0;
    step();
    step();
    bfm_delay = 3;
    bus.req_data = 32'h0000A500;
    bus.req_valid = 4'b0010;
    #1 chk("single_ready", bus.req_ready, 4'b0010);
    step();
    #1 chk("single_start", bus.uart_start_tx, 1);
    chk("single_data", bus.uart_tx_data, 8'hA5);
    chk("single_gid", bus.grant_id, 1);
    step();
    #1 chk("single_start_once", bus.uart_start_tx, 0);
    repeat (3) step();
    #1 chk("single_done", bus.req_done, 4'b0010);
    step();
    #1 chk("single_done_pulse", bus.req_done, 0);
    wait_idle();
    step();
    bfm_delay = 0;
    bus.req_data = 32'h5A000000;
    bus.req_valid = 4'b1000;
    step();
    #1 chk("to_launch", bus.uart_start_tx, 1);
    repeat (8) step();
    #1 chk("to_early", bus.timeout_err, 0);
    step();
    #1 chk("to_pulse", bus.timeout_err, 1);
    chk("to_no_done", bus.req_done, 0);
    chk("to_idle", bus.active, 0);
    step();
    #1 chk("to_pulse_end", bus.timeout_err, 0);
    bus.req_data = 32'h13121110;
    bus.req_valid = 4'hF;
    refill = 1;
    bfm_delay = 2;
    rx_q.delete();
    gnt_q.delete();
    #1 chk("to_next_grant", bus.req_ready, 4'b0001);
    begin
      int t = 0;
      while (rx_q.size() < 5 && t < 200) begin
        step();
        t++;
      end
    end
    refill = 0;
    bus.req_valid = 0;
    chk("fair_count", rx_q.size() >= 5, 1);
    for (int i = 0; i < 5; i++) begin
      chk("fair_grant", gnt_q[i], exp_order[i]);
      chk("fair_byte", rx_q[i], 32'(8'h10 + exp_order[i]));
    end
    wait_idle();
    step();
    bfm_delay = 8;
    bus.req_data = 32'h00770000;
    bus.req_valid = 4'b0100;
    step();
    repeat (8) step();
    #1 chk("coinc_to_early", bus.timeout_err, 0);
    step();
    #1 chk("coinc_done", bus.req_done, 4'b0100);
    chk("coinc_no_to", bus.timeout_err, 0);
    step();
    bus.uart_tx_done = 1;
    step();
    #1 chk("stale_done", bus.req_done, 0);
    chk("stale_active", bus.active, 0);
    bfm_delay = 4;
    bus.req_data = 32'h00000201;
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = 4'b0010;
    step();
    step();
    bus.req_valid = 0;
    rx_q.delete();
    repeat (6) step();
    #1 chk("withdraw_idle", bus.active, 0);
    chk("withdraw_nolaunch", rx_q.size(), 0);
    bfm_delay = 0;
    bus.req_data = 32'h000000C3;
    bus.req_valid = 4'b0001;
    repeat (3) step();
    #1 chk("midrst_active", bus.active, 1);
    rst = 1;
    #1 chk_zero("midrst");
    step();
    step();
    rst = 0;
    bfm_delay = 2;
    bus.req_data = 32'h003C0000;
    bus.req_valid = 4'b0100;
    #1 chk("postrst_ready", bus.req_ready, 4'b0100);
    step();
    #1 chk("postrst_start", bus.uart_start_tx, 1);
    chk("postrst_data", bus.uart_tx_data, 8'h3C);
    chk("postrst_gid", bus.grant_id, 2);
    wait_idle();
    step();
    rnd = 1;
    repeat (2500) step();
    rnd = 0;
    bus.req_valid = 0;
    wait_idle();
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_transmitter` between N independent requesters (CPU mailbox, debug logger, status reporter, etc.). Requesters hand over one byte each through a valid/ready handshake. The arbiter selects one byte by round-robin and launches it on the transmitter. It then holds the transmitter until `tx_done` and reports completion or timeout back to the owner. It sits directly in front of `uart_transmitter` and is the only block allowed to drive its `start_tx`/`tx_data`.

## Interface
- `NUM_REQ`, 4, number of requesters (1..16)
- `DATA_W`, 8, byte width, must match the transmitter
- `TIMEOUT_CYCLES`, 200000, cycles allowed from launch to `tx_done` before abort (≥ 4)
- `clk` in 1, system clock; all logic on rising edge
- `rst` in 1, asynchronous, active-high reset
- `req_valid` in NUM_REQ, requester i holds a byte ready
- `req_data` in NUM_REQ*DATA_W, byte of requester i at `[i*DATA_W +: DATA_W]`
- `req_ready` out NUM_REQ, one-hot accept; handshake completes when `req_valid[i] & req_ready[i]`
- `req_done` out NUM_REQ, one-cycle pulse to the owner when its byte finished
- `uart_start_tx` out 1, to transmitter `start_tx`
- `uart_tx_data` out DATA_W, to transmitter `tx_data`
- `uart_tx_busy` in 1, from transmitter `tx_busy`
- `uart_tx_done` in 1, from transmitter `tx_done`
- `grant_id` out max(1,$clog2(NUM_REQ)), index of current owner
- `active` out 1, high in LAUNCH or WAIT
- `timeout_err` out 1, one-cycle pulse on abort

## Operation
- States: IDLE, LAUNCH, WAIT.
- **IDLE**
  - Round-robin pick among `req_valid`, starting at pointer `ptr`.
  - Assert `req_ready` only for the winner, combinationally.
  - On the handshake:
    - latch data into `uart_tx_data`;
    - set `grant_id` = winner;
    - go to LAUNCH.
  - No valid requester: stay in IDLE with all `req_ready` = 0.
- **LAUNCH**
  - `uart_start_tx` = 1 for exactly this one cycle.
  - Go to WAIT.
- **WAIT**
  - Hold `uart_tx_data` stable.
  - On `uart_tx_done` = 1:
    - pulse `req_done[grant_id]` next cycle (registered);
    - set `ptr` = (`grant_id`+1) mod NUM_REQ;
    - go to IDLE.
- **Timeout**
  - Counter clears on entering LAUNCH and increments each cycle in LAUNCH/WAIT.
  - When it reaches TIMEOUT_CYCLES with no `uart_tx_done`:
    - pulse `timeout_err` next cycle;
    - do not pulse `req_done`;
    - advance `ptr` as for a normal completion;
    - go to IDLE.
- **Ignored inputs**
  - `uart_tx_done` in IDLE or LAUNCH is stale and ignored.
  - `uart_tx_busy` is status only: it never gates transitions.
- **Non-winning requesters** keep `req_valid` asserted; there is no queueing inside the block.
- **Pointer wrap**
  - `ptr` wraps from NUM_REQ-1 to 0.
  - With NUM_REQ = 1, `ptr` stays 0.

## Timing
- **Reset values**
  - state IDLE, `ptr` 0, counter 0.
  - `req_ready` 0, `req_done` 0, `uart_start_tx` 0, `uart_tx_data` 0, `grant_id` 0, `active` 0, `timeout_err` 0.
- **Latency**
  - Handshake in cycle T → `uart_start_tx` high in T+1 → WAIT from T+2.
  - `uart_tx_done` sampled in cycle D → `req_done` high in D+1.
  - Next handshake is possible at the earliest in D+1, since IDLE is entered at D+1.
- **Handshake contract**
  - A requester must hold `req_valid` and `req_data` stable until `req_ready`.
  - Dropping `req_valid` before the grant withdraws the request without error.
- **Simultaneous events**
  - `uart_tx_done` in the same cycle the counter hits the limit counts as success (`req_done`, no `timeout_err`).
- **Reset mid-operation**
  - Immediately returns to IDLE with all outputs at reset values.
  - No `req_done` is issued for the byte in flight.
- **Fairness**: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W` = 8;
  - state enum `uart_arb_state_t` {IDLE, LAUNCH, WAIT};
  - the transmitter's expected frame length, used to size TIMEOUT_CYCLES.
- One sub-module: `rr_arbiter` (NUM_REQ).
  - Combinational: inputs `req`, `ptr`; outputs one-hot `gnt`, index `gnt_id`, `any`.
  - Reused elsewhere for other shared peripherals.

## Test plan
- **Reset**: `rst`=1 mid-WAIT → next edge all outputs 0, state IDLE; a later request on requester 2 is granted normally.
- **Single requester**: `req_valid`=4'b0010, data 8'hA5.
  - `req_ready`=4'b0010 in T, `uart_start_tx`=1 only in T+1 with `uart_tx_data`=8'hA5.
  - BFM `tx_done` at D → `req_done`=4'b0010 at D+1.
- **Fairness**: all four valid with data 8'h10..8'h13 → grant order 0,1,2,3,0; the transmitter BFM receives bytes in that order.
- **Timeout**: TIMEOUT_CYCLES=8 and the BFM never asserts `tx_done` → `timeout_err` pulses 9 cycles after the LAUNCH cycle; no `req_done`; the next grant goes to the next index.
- **Boundary**:
  - `tx_done` coincident with the timeout limit → `req_done` only.
  - Stale `tx_done` in IDLE → ignored.
  - `req_valid` withdrawn before grant → no launch.
